div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divide sequencer for the EX stage. It accepts one DIV/DIVU request from EX and runs a 32-step restoring division, one quotient bit per cycle. While the operation is in flight it holds the pipeline through `stall_request`. It returns the quotient (LO) and remainder (HI) for one cycle on `result_valid`, and a pipeline flush can abort an in-flight operation.

## Interface
- `DATA_WIDTH`, default 32: operand and result width; the step counter is sized to log2(`DATA_WIDTH`).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `start` in 1: EX requests a division; EX holds it high until it sees `result_valid`.
- `annul` in 1: flush; cancels any request or in-flight operation.
- `signed_op` in 1: 1 = DIV (signed), 0 = DIVU.
- `dividend` in `DATA_WIDTH`: operand1 from EX; sampled only on acceptance.
- `divisor` in `DATA_WIDTH`: operand2 from EX; sampled only on acceptance.
- `stall_request` out 1: to pipeline control; freezes IF/ID/EX.
- `result_valid` out 1: quotient/remainder valid this cycle.
- `quotient` out `DATA_WIDTH`: destined for LO.
- `remainder` out `DATA_WIDTH`: destined for HI.

## Operation
- States: IDLE, DIV_ZERO, BUSY, DONE.
- **IDLE**
  - Acceptance: `start` && !`annul`.
  - Divisor == 0 → DIV_ZERO.
  - Otherwise: latch |dividend| and |divisor| (absolute values only when signed), latch both sign bits, clear the step counter → BUSY.
- **DIV_ZERO**
  - → DONE with quotient = 0, remainder = 0 (MIPS leaves this undefined; we fix it to zero).
- **BUSY**, each cycle:
  - Shift {partial_rem[`DATA_WIDTH`:0], quo} left by 1.
  - trial = partial_rem − {0, divisor}.
  - If trial ≥ 0: partial_rem = trial and quotient LSB = 1; else restore and LSB = 0.
  - Partial remainder is `DATA_WIDTH`+1 bits wide.
  - Counter increments from 0; the step taken with counter == `DATA_WIDTH`−1 → DONE.
- **DONE**, on entry:
  - Apply sign fixup (signed only): negate quotient if the operand signs differ; negate remainder if the dividend was negative.
  - Register the fixed-up values into `quotient`/`remainder`.
  - Unconditionally → IDLE after one cycle; a `start` still high during DONE is not re-accepted that cycle.
- Outputs:
  - `stall_request` = (IDLE && `start` && !`annul`) || DIV_ZERO || BUSY. Combinational; 0 in DONE so the pipeline advances.
  - `result_valid` = DONE && !`annul`.
  - `quotient`/`remainder` hold their last result until the next DONE entry.
- **Annul**
  - In DIV_ZERO or BUSY: → IDLE next edge; no `result_valid`; outputs unchanged.
  - In IDLE: the request is not accepted.
  - In DONE: `result_valid` is suppressed.
- **Reset**
  - State IDLE, counter 0, `quotient` = `remainder` = 0, `result_valid` = 0, `stall_request` = 0 (given `start` low).
  - Any in-flight operation is dropped.

## Timing
- Acceptance edge = cycle 0.
  - Nonzero divisor: BUSY cycles 1..32, DONE (`result_valid` high) at cycle 33.
  - Zero divisor: DIV_ZERO at cycle 1, DONE at cycle 2.
- `stall_request`:
  - Nonzero divisor: high combinationally in cycle 0 and in cycles 1..32; low in cycle 33.
  - Zero divisor: high in cycles 0..1, low in cycle 2.
- `result_valid` is high for exactly one cycle per completed operation.
- Earliest back-to-back acceptance is the cycle after DONE.
- Operand inputs are don't-care after acceptance.
- Reset wins over `annul`; `annul` wins over `start`.

## Configuration
- `DIV_SIGNED_EN`
  - Defined: signed operands are converted to absolute values at acceptance and sign fixup is applied at DONE, per `signed_op`.
  - Undefined: `signed_op` is ignored, all divisions are unsigned, and the sign registers and negation logic are omitted.
  - Cycle timing is identical in both cases.

## Test plan
- Unsigned 100 / 7 → `result_valid` at cycle 33, quotient 14, remainder 2; `stall_request` high in cycles 0..32, low in 33.
- Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0 at cycle 33.
- Divisor 0 (dividend 55) → DIV_ZERO; quotient 0, remainder 0 at cycle 2; `stall_request` high in cycles 0..1.
- With `DIV_SIGNED_EN`, signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Without `DIV_SIGNED_EN`, the same operands → quotient 0x7FFFFFFC, remainder 1.
- `annul` pulsed at cycle 10 of BUSY → IDLE at cycle 11; `stall_request` low; no `result_valid`; prior quotient/remainder unchanged. A new request 20 / 3 then returns quotient 6, remainder 2.
- `reset` asserted at cycle 5 of BUSY → next cycle: state IDLE, outputs 0. With `start` low, there is no `stall_request` and no `result_valid` afterwards.

Source files
------------

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: request/result bundle between the EX stage and the divide sequencer.
// Latency: n/a (wires only); the sequencer answers 33 cycles after acceptance (2 for a zero divisor).
// Backpressure: the sequencer raises stall_request to freeze IF/ID/EX while an operation is in flight.
//
// Ports (master = EX stage, slave = div_ctrl):
//   start, annul, signed_op, dividend, divisor           EX -> divider
//   stall_request, result_valid, quotient, remainder     divider -> EX / pipeline control
interface div_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  annul;
   logic                  signed_op;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  stall_request;
   logic                  result_valid;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;

   modport master (
      output start, annul, signed_op, dividend, divisor,
      input  stall_request, result_valid, quotient, remainder
   );

   modport slave (
      input  start, annul, signed_op, dividend, divisor,
      output stall_request, result_valid, quotient, remainder
   );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider (DIV/DIVU) for the EX stage, one quotient bit per cycle.
// Latency: result_valid 33 cycles after the acceptance edge (2 cycles for a zero divisor).
// Backpressure: stall_request holds the pipeline from the request cycle until the result cycle.
//
// Ports:
//   clock          single rising-edge clock
//   reset          synchronous, active-high
//   bus (slave)    start/annul/signed_op/dividend/divisor in;
//                  stall_request/result_valid/quotient(LO)/remainder(HI) out
// Build option: define DIV_SIGNED_EN to honour signed_op (signed DIV); without it every
// division is unsigned and the sign tracking/negation hardware is not built.
module div_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic      clock,
   input  logic      reset,
   div_ctrl_if.slave bus
);

   localparam int                CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_ZERO = 2'd1,
      BUSY     = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      step_cnt;
   logic [DATA_WIDTH:0]   part_rem;     // one guard bit above the divisor width
   logic [DATA_WIDTH-1:0] quo;          // holds the dividend, shifted out as quotient bits shift in
   logic [DATA_WIDTH-1:0] dvsr;
   logic [DATA_WIDTH-1:0] quotient_r;
   logic [DATA_WIDTH-1:0] remainder_r;

   logic                  accept;
   logic [DATA_WIDTH-1:0] mag_dividend;
   logic [DATA_WIDTH-1:0] mag_divisor;

   logic [DATA_WIDTH+1:0] shifted;
   logic [DATA_WIDTH+1:0] trial;
   logic                  take;
   logic [DATA_WIDTH:0]   next_rem;
   logic [DATA_WIDTH-1:0] next_quo;
   logic [DATA_WIDTH-1:0] fixed_quo;
   logic [DATA_WIDTH-1:0] fixed_rem;

   // annul outranks start: a flushed request is never taken
   assign accept = (state == IDLE) && bus.start && !bus.annul;

   // ------------------------------------------------------------------
   // Operand conditioning and final sign correction
   // ------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
   logic in_neg_dividend;
   logic in_neg_divisor;
   logic neg_quo;     // operand signs differed
   logic neg_rem;     // remainder follows the dividend's sign

   assign in_neg_dividend = bus.signed_op && bus.dividend[DATA_WIDTH-1];
   assign in_neg_divisor  = bus.signed_op && bus.divisor[DATA_WIDTH-1];

   // The most negative value maps onto itself, which is the correct unsigned magnitude.
   assign mag_dividend = in_neg_dividend ? (~bus.dividend + 1'b1) : bus.dividend;
   assign mag_divisor  = in_neg_divisor  ? (~bus.divisor  + 1'b1) : bus.divisor;

   assign fixed_quo = neg_quo ? (~next_quo + 1'b1) : next_quo;
   assign fixed_rem = neg_rem ? (~next_rem[DATA_WIDTH-1:0] + 1'b1) : next_rem[DATA_WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else if (accept) begin
         neg_quo <= in_neg_dividend ^ in_neg_divisor;
         neg_rem <= in_neg_dividend;
      end
   end
`else
   logic unused_signed_op;

   assign unused_signed_op = bus.signed_op;
   assign mag_dividend     = bus.dividend;
   assign mag_divisor      = bus.divisor;
   assign fixed_quo        = next_quo;
   assign fixed_rem        = next_rem[DATA_WIDTH-1:0];
`endif

   // ------------------------------------------------------------------
   // One restoring step: shift {rem, quo} left, trial-subtract the divisor
   // ------------------------------------------------------------------
   always_comb begin
      shifted  = {part_rem, quo[DATA_WIDTH-1]};
      trial    = shifted - {2'b00, dvsr};
      // part_rem stays below the divisor, so the top bit of trial is a true borrow
      take     = !trial[DATA_WIDTH+1];
      next_rem = take ? trial[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
      next_quo = {quo[DATA_WIDTH-2:0], take};
   end

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         step_cnt    <= '0;
         part_rem    <= '0;
         quo         <= '0;
         dvsr        <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.divisor == '0) begin
                     state <= DIV_ZERO;
                  end else begin
                     part_rem <= '0;
                     quo      <= mag_dividend;
                     dvsr     <= mag_divisor;
                     step_cnt <= '0;
                     state    <= BUSY;
                  end
               end
            end

            DIV_ZERO: begin
               if (bus.annul) begin
                  state <= IDLE;
               end else begin
                  // architecturally undefined; pinned to zero so software sees a fixed value
                  quotient_r  <= '0;
                  remainder_r <= '0;
                  state       <= DONE;
               end
            end

            BUSY: begin
               if (bus.annul) begin
                  state <= IDLE;
               end else begin
                  part_rem <= next_rem;
                  quo      <= next_quo;
                  step_cnt <= step_cnt + 1'b1;
                  if (step_cnt == LAST_STEP) begin
                     // final step result goes straight into the output registers
                     quotient_r  <= fixed_quo;
                     remainder_r <= fixed_rem;
                     state       <= DONE;
                  end
               end
            end

            DONE: begin
               // start is still high here; it is deliberately not taken until IDLE
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The request cycle itself must stall, before the FSM has left IDLE.
   assign bus.stall_request = accept || (state == DIV_ZERO) || (state == BUSY);
   assign bus.result_valid  = (state == DONE) && !bus.annul;
   assign bus.quotient      = quotient_r;
   assign bus.remainder     = remainder_r;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl.
// A cycle-level reference model (plain arithmetic plus a countdown to the result cycle)
// is compared against every DUT output on every cycle outside reset; directed operations
// additionally pin latency, stall length and result values to hand-computed literals.
module tb_div_ctrl;

   localparam int W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   div_ctrl_if #(.DATA_WIDTH(W)) bus ();

   div_ctrl #(.DATA_WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference division: magnitudes divided, then signs restored (quotient negative when
   // signs differ, remainder takes the dividend's sign). Zero divisor gives 0/0.
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         na;
      logic         nb;
      logic [W-1:0] ma;
      logic [W-1:0] mb;
      if (b == 0) return '0;
`ifdef DIV_SIGNED_EN
      na = s && a[W-1];
      nb = s && b[W-1];
`else
      na = 1'b0;
      nb = 1'b0;
      if (s) na = 1'b0;
`endif
      ma = na ? -a : a;
      mb = nb ? -b : b;
      q  = ma / mb;
      r  = ma % mb;
      if (na ^ nb) q = -q;
      if (na)      r = -r;
      return {q, r};
   endfunction

   // ------------------------------------------------------------------
   // Reference model and per-cycle compare
   // ------------------------------------------------------------------
   bit           m_busy = 1'b0;   // accepted, result not yet presented
   bit           m_done = 1'b0;   // this is the result cycle
   int           m_left = 0;      // edges until the result cycle
   logic [W-1:0] m_pq = '0, m_pr = '0;   // pending result
   logic [W-1:0] m_q  = '0, m_r  = '0;   // visible outputs

   always @(negedge clock) begin
      if (reset) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q    = '0;
         m_r    = '0;
      end else begin
         chk("stall_request", W'(bus.stall_request),
             W'(m_busy || (!m_done && bus.start && !bus.annul)));
         chk("result_valid", W'(bus.result_valid), W'(m_done && !bus.annul));
         chk("quotient", bus.quotient, m_q);
         chk("remainder", bus.remainder, m_r);
         // advance to the state after the coming edge
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_busy) begin
            if (bus.annul) begin
               m_busy = 1'b0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
                  m_q    = m_pq;
                  m_r    = m_pr;
               end
            end
         end else if (bus.start && !bus.annul) begin
            m_busy       = 1'b1;
            m_left       = (bus.divisor == 0) ? 1 : 32;
            {m_pq, m_pr} = ref_div(bus.dividend, bus.divisor, bus.signed_op);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (entered and left 1 time unit after a rising edge)
   // ------------------------------------------------------------------
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output int stalls, output logic stall_at_done,
                         output logic [W-1:0] q, output logic [W-1:0] r);
      lat           = -1;
      stalls        = 0;
      stall_at_done = 1'bx;
      q             = 'x;
      r             = 'x;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.signed_op = s;
      bus.start     = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clock);
         if (bus.result_valid) begin
            lat           = n;
            stall_at_done = bus.stall_request;
            q             = bus.quotient;
            r             = bus.remainder;
            break;
         end
         if (bus.stall_request) stalls++;
         @(posedge clock); #1;
      end
      if (lat < 0) $display("FAIL timeout: no result_valid for %h / %h", a, b);
      if (lat >= 0) begin
         @(posedge clock); #1;
      end
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   task automatic idle_watch(input int n, output int valids, output int stalls);
      valids = 0;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (bus.result_valid)  valids++;
         if (bus.stall_request) stalls++;
      end
      @(posedge clock); #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat, stalls, valids, istalls;
      logic         sd;
      logic [W-1:0] q, r;
      logic [W-1:0] neg7;
      logic [W-1:0] sq_exp, sr_exp;

      bus.start     = 1'b0;
      bus.annul     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // reset state
      @(negedge clock);
      chk("reset stall_request", W'(bus.stall_request), '0);
      chk("reset result_valid", W'(bus.result_valid), '0);
      chk("reset quotient", bus.quotient, '0);
      chk("reset remainder", bus.remainder, '0);
      @(posedge clock); #1;

      // unsigned 100 / 7
      run_op(32'd100, 32'd7, 1'b0, lat, stalls, sd, q, r);
      chk("100/7 latency", W'(lat), 32'd33);
      chk("100/7 stall cycles", W'(stalls), 32'd33);
      chk("100/7 stall in result cycle", W'(sd), 32'd0);
      chk("100/7 quotient", q, 32'd14);
      chk("100/7 remainder", r, 32'd2);

      // all ones / 1, back to back
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, stalls, sd, q, r);
      chk("ffffffff/1 latency", W'(lat), 32'd33);
      chk("ffffffff/1 quotient", q, 32'hFFFF_FFFF);
      chk("ffffffff/1 remainder", r, 32'd0);

      // zero divisor
      run_op(32'd55, 32'd0, 1'b0, lat, stalls, sd, q, r);
      chk("55/0 latency", W'(lat), 32'd2);
      chk("55/0 stall cycles", W'(stalls), 32'd2);
      chk("55/0 stall in result cycle", W'(sd), 32'd0);
      chk("55/0 quotient", q, 32'd0);
      chk("55/0 remainder", r, 32'd0);

      // -7 / 2 with signed_op set
      neg7 = 32'hFFFF_FFF9;
`ifdef DIV_SIGNED_EN
      sq_exp = 32'hFFFF_FFFD;
      sr_exp = 32'hFFFF_FFFF;
`else
      sq_exp = 32'h7FFF_FFFC;
      sr_exp = 32'h0000_0001;
`endif
      run_op(neg7, 32'd2, 1'b1, lat, stalls, sd, q, r);
      chk("-7/2 latency", W'(lat), 32'd33);
      chk("-7/2 quotient", q, sq_exp);
      chk("-7/2 remainder", r, sr_exp);

      // annul in BUSY cycle 10
      bus.dividend  = 32'd1000;
      bus.divisor   = 32'd3;
      bus.signed_op = 1'b0;
      bus.start     = 1'b1;
      repeat (10) begin
         @(posedge clock); #1;
      end
      bus.annul = 1'b1;
      bus.start = 1'b0;
      @(posedge clock); #1;
      bus.annul = 1'b0;
      @(negedge clock);
      chk("annul stall after flush", W'(bus.stall_request), '0);
      @(posedge clock); #1;
      idle_watch(40, valids, istalls);
      chk("annul no result_valid", W'(valids), '0);
      chk("annul quotient held", bus.quotient, sq_exp);
      chk("annul remainder held", bus.remainder, sr_exp);
      run_op(32'd20, 32'd3, 1'b0, lat, stalls, sd, q, r);
      chk("20/3 quotient", q, 32'd6);
      chk("20/3 remainder", r, 32'd2);

      // reset in BUSY cycle 5
      bus.dividend = 32'd5000;
      bus.divisor  = 32'd7;
      bus.start    = 1'b1;
      repeat (5) begin
         @(posedge clock); #1;
      end
      reset     = 1'b1;
      bus.start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("post-reset quotient", bus.quotient, '0);
      chk("post-reset remainder", bus.remainder, '0);
      chk("post-reset stall_request", W'(bus.stall_request), '0);
      @(posedge clock); #1;
      idle_watch(40, valids, istalls);
      chk("post-reset result_valid count", W'(valids), '0);
      chk("post-reset stall count", W'(istalls), '0);

      // randomized operations, some flushed mid-flight; the model checks every cycle
      for (int k = 0; k < 60; k++) begin
         logic [W-1:0] a, b;
         int           annul_at;
         bit           got;
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 15));
            3:       b = {$urandom} | 32'h8000_0000;
            default: b = $urandom;
         endcase
         a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 200)) : W'($urandom);
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         annul_at      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 33)) : -1;
         bus.dividend  = a;
         bus.divisor   = b;
         bus.signed_op = 1'($urandom);
         bus.start     = 1'b1;
         got           = 1'b0;
         for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            got = bus.result_valid;
            @(posedge clock); #1;
            if (got) break;
            if (n + 1 == annul_at) begin
               bus.annul = 1'b1;
               bus.start = 1'b0;
               @(posedge clock); #1;
               bus.annul = 1'b0;
               break;
            end
         end
         bus.start = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clock); #1;
         end
      end

      repeat (3) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
